// File: rtl/seq_shifter_if.sv
// Operand/result handshake bundle between the ALU controller and seq_shifter.
// master = controller side, slave = shifter side.
interface seq_shifter_if #(
    parameter int WIDTH = 16,
    parameter int AMT_W = $clog2(WIDTH)
) ();
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [AMT_W-1:0] in_amt;
    logic [1:0]       in_mode;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;

    modport master (
        output in_valid, in_data, in_amt, in_mode, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, in_amt, in_mode, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/seq_shifter.sv
// Multi-cycle shifter (LSL/LSR/ASR/ROR), up to STEP bit positions per clock.
// Optional carry-out port cout is enabled by defining SEQ_SHIFTER_CARRY_EN.
//
// state  | meaning
// IDLE   | waiting for an operation, in_ready high
// SHIFT  | shifting min(STEP, remaining) bits per clock
// HOLD   | result presented with out_valid until out_ready
module seq_shifter #(
    parameter int WIDTH = 16,
    parameter int AMT_W = $clog2(WIDTH),
    parameter int STEP  = 1
) (
    input  logic          clk,
    input  logic          reset_n,
    seq_shifter_if.slave  bus,
    output logic          busy
`ifdef SEQ_SHIFTER_CARRY_EN
    ,
    output logic          cout
`endif
);

    localparam int SW = AMT_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        M_LSL = 2'b00,
        M_LSR = 2'b01,
        M_ASR = 2'b10,
        M_ROR = 2'b11
    } mode_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [AMT_W-1:0] rem_q, rem_d;
    mode_t            mode_q, mode_d;

    logic [SW-1:0]    step_amt;
    logic [WIDTH-1:0] lsl_res, lsr_res, asr_res, ror_res;

`ifdef SEQ_SHIFTER_CARRY_EN
    logic             carry_q, carry_d;
    logic             carry_l, carry_r;
`endif

    // STEP may equal WIDTH, so the step amount carries one extra bit of headroom.
    always_comb begin
        step_amt = ({1'b0, rem_q} < SW'(STEP)) ? {1'b0, rem_q} : SW'(STEP);
        lsl_res  = data_q << step_amt;
        lsr_res  = data_q >> step_amt;
        asr_res  = $signed(data_q) >>> step_amt;
        ror_res  = (data_q >> step_amt) | (data_q << (SW'(WIDTH) - step_amt));
    end

`ifdef SEQ_SHIFTER_CARRY_EN
    // Only evaluated in SHIFT, where 1 <= step_amt <= WIDTH-1.
    always_comb begin
        carry_l = |(data_q & (WIDTH'(1) << (SW'(WIDTH) - step_amt)));
        carry_r = |(data_q & (WIDTH'(1) << (step_amt - SW'(1))));
    end
`endif

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        rem_d   = rem_q;
        mode_d  = mode_q;
`ifdef SEQ_SHIFTER_CARRY_EN
        carry_d = carry_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    data_d  = bus.in_data;
                    rem_d   = bus.in_amt;
                    mode_d  = mode_t'(bus.in_mode);
`ifdef SEQ_SHIFTER_CARRY_EN
                    carry_d = 1'b0;
`endif
                    state_d = (bus.in_amt == '0) ? ST_HOLD : ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                case (mode_q)
                    M_LSL:   data_d = lsl_res;
                    M_LSR:   data_d = lsr_res;
                    M_ASR:   data_d = asr_res;
                    default: data_d = ror_res;
                endcase
`ifdef SEQ_SHIFTER_CARRY_EN
                carry_d = (mode_q == M_LSL) ? carry_l : carry_r;
`endif
                rem_d = rem_q - step_amt[AMT_W-1:0];
                if (step_amt == {1'b0, rem_q}) begin
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (bus.out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            data_q  <= '0;
            rem_q   <= '0;
            mode_q  <= M_LSL;
`ifdef SEQ_SHIFTER_CARRY_EN
            carry_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            rem_q   <= rem_d;
            mode_q  <= mode_d;
`ifdef SEQ_SHIFTER_CARRY_EN
            carry_q <= carry_d;
`endif
        end
    end

    assign bus.in_ready  = (state_q == ST_IDLE);
    assign bus.out_valid = (state_q == ST_HOLD);
    assign bus.out_data  = data_q;
    assign busy          = (state_q != ST_IDLE);
`ifdef SEQ_SHIFTER_CARRY_EN
    assign cout          = carry_q;
`endif

endmodule
